// File: rtl/mrc_pkg.sv
// ============================================================================
// mrc_pkg: shared FSM states, default widths and saturating-add helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package mrc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CMP  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_ACC_W = 32;

  // Unsigned x + y clamped to 2^w-1; callers zero-extend into 64 bits (w <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] x,
                                          input logic [63:0] y,
                                          input int          w);
    logic [64:0] sum;
    logic [63:0] lim;
    sum = {1'b0, x} + {1'b0, y};
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (sum > {1'b0, lim}) return lim;
    return sum[63:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mrc_shift_add.sv
// ============================================================================
// mrc_shift_add: iterative shift-add unsigned multiplier, WIDTH cycles/product
// Revision: 1.0
// ============================================================================
`default_nettype none

module mrc_shift_add
  import mrc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int            IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  logic                 busy;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [IW-1:0]        iter;

  // High during the final iteration; product is exact on the following cycle.
  assign done = busy && (iter == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      iter    <= '0;
      product <= '0;
    end else if (clear) begin
      busy    <= 1'b0;
      iter    <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      iter    <= '0;
      product <= '0;
    end else if (busy) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      iter   <= iter + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_result_checker.sv
// ============================================================================
// mult_result_checker: scores (A, B, P) triples against an exact shift-add
// product and accumulates error metrics. Optional: MRC_BIAS_EN adds err_bias.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_result_checker
  import mrc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_a,
  input  logic [WIDTH-1:0]        in_b,
  input  logic [2*WIDTH-1:0]      in_p,
  output logic                    res_valid,
  output logic                    res_mismatch,
  output logic [CNT_W-1:0]        sample_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [ACC_W-1:0]        err_sum,
`ifdef MRC_BIAS_EN
  output logic signed [ACC_W-1:0] err_bias,
`endif
  output logic [2*WIDTH-1:0]      err_max
);

  state_t               state, state_nx;
  logic                 start;
  logic                 done;
  logic [2*WIDTH-1:0]   exact;
  logic [2*WIDTH-1:0]   p_q;
  logic [2*WIDTH-1:0]   diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    start    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          start    = 1'b1;
          state_nx = MUL;
        end
      end
      MUL:     if (done) state_nx = CMP;
      CMP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // clear wins over everything, including a same-cycle accept.
    if (clear) begin
      state_nx = IDLE;
      start    = 1'b0;
    end
  end

  mrc_shift_add #(.WIDTH(WIDTH)) u_engine (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .start   (start),
    .a       (in_a),
    .b       (in_b),
    .done    (done),
    .product (exact)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        p_q <= '0;
    else if (start) p_q <= in_p;
  end

  assign diff = (p_q >= exact) ? (p_q - exact) : (exact - p_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid    <= 1'b0;
      res_mismatch <= 1'b0;
      sample_cnt   <= '0;
      err_cnt      <= '0;
      err_sum      <= '0;
      err_max      <= '0;
    end else if (clear) begin
      res_valid    <= 1'b0;
      res_mismatch <= 1'b0;
      sample_cnt   <= '0;
      err_cnt      <= '0;
      err_sum      <= '0;
      err_max      <= '0;
    end else begin
      res_valid <= (state == CMP);
      if (state == CMP) begin
        res_mismatch <= (diff != '0);
        sample_cnt   <= CNT_W'(sat_add(64'(sample_cnt), 64'd1, CNT_W));
        if (diff != '0)
          err_cnt <= CNT_W'(sat_add(64'(err_cnt), 64'd1, CNT_W));
        err_sum <= ACC_W'(sat_add(64'(err_sum), 64'(diff), ACC_W));
        if (diff > err_max) err_max <= diff;
      end
    end
  end

`ifdef MRC_BIAS_EN
  logic signed [2*WIDTH:0] sdiff;
  logic signed [ACC_W:0]   bias_sum;

  assign sdiff    = $signed({1'b0, p_q}) - $signed({1'b0, exact});
  assign bias_sum = {err_bias[ACC_W-1], err_bias} + (ACC_W+1)'(sdiff);

  // Differing top two bits of the widened sum mean the signed range was exceeded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_bias <= '0;
    end else if (clear) begin
      err_bias <= '0;
    end else if (state == CMP) begin
      if (bias_sum[ACC_W] != bias_sum[ACC_W-1])
        err_bias <= bias_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
      else
        err_bias <= bias_sum[ACC_W-1:0];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_result_checker.sv
// ============================================================================
// tb_mult_result_checker: directed vectors for WIDTH=8 and WIDTH=2/CNT_W=2
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mult_result_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        clr8 = 0, v8 = 0, rdy8, rv8, rm8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8 = 0, sc8, ec8, em8;
  logic [31:0] es8;
  // WIDTH=2, CNT_W=2 instance
  logic        clr2 = 0, v2 = 0, rdy2, rv2, rm2;
  logic [1:0]  a2 = 0, b2 = 0, sc2, ec2;
  logic [3:0]  p2 = 0, em2;
  logic [31:0] es2;
`ifdef MRC_BIAS_EN
  logic signed [31:0] bias8, bias2;
`endif

  mult_result_checker dut8 (
    .clk(clk), .rst(rst), .clear(clr8), .in_valid(v8), .in_ready(rdy8),
    .in_a(a8), .in_b(b8), .in_p(p8), .res_valid(rv8), .res_mismatch(rm8),
    .sample_cnt(sc8), .err_cnt(ec8), .err_sum(es8),
`ifdef MRC_BIAS_EN
    .err_bias(bias8),
`endif
    .err_max(em8)
  );

  mult_result_checker #(.WIDTH(2), .CNT_W(2), .ACC_W(32)) dut2 (
    .clk(clk), .rst(rst), .clear(clr2), .in_valid(v2), .in_ready(rdy2),
    .in_a(a2), .in_b(b2), .in_p(p2), .res_valid(rv2), .res_mismatch(rm2),
    .sample_cnt(sc2), .err_cnt(ec2), .err_sum(es2),
`ifdef MRC_BIAS_EN
    .err_bias(bias2),
`endif
    .err_max(em2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one triple to instance d (0: WIDTH=8, 1: WIDTH=2); returns mismatch
  // flag and res_valid latency in edges after the accept edge (-1 on timeout).
  task automatic send(input bit d, input int a, input int b, input int p,
                      output logic mis, output int lat);
    int g;
    bit rbad;
    g = 0;
    while (!(d ? rdy2 : rdy8) && g < 40) begin tick(); g++; end
    if (d) begin v2 = 1; a2 = 2'(a); b2 = 2'(b); p2 = 4'(p); end
    else   begin v8 = 1; a8 = 8'(a); b8 = 8'(b); p8 = 16'(p); end
    tick();
    v2 = 0; v8 = 0;
    lat = -1; mis = 0; rbad = 0;
    for (int k = 0; k <= 30 && lat < 0; k++) begin
      if (k > 0) tick();
      if (d ? rv2 : rv8) begin
        lat = k;
        mis = d ? rm2 : rm8;
      end else if (d ? rdy2 : rdy8) begin
        rbad = 1;
      end
    end
    chk("ready_low_while_busy", 64'(rbad), 0);
  endtask

  task automatic do_clear(input bit d);
    if (d) clr2 = 1; else clr8 = 1;
    tick();
    clr2 = 0; clr8 = 0;
  endtask

  typedef struct {
    int a;
    int b;
    int p;
    bit mis;
  } vec_t;

  vec_t tv[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic mis;
    int   lat, acc, last, pulses;
    bit   bad_gap;

    tv[0] = '{255, 255, 65025, 1'b0};
    tv[1] = '{0,   200, 0,     1'b0};
    tv[2] = '{200, 0,   5,     1'b1};  // diff 5
    tv[3] = '{17,  13,  221,   1'b0};
    tv[4] = '{12,  10,  100,   1'b1};  // diff 20, P below exact
    tv[5] = '{255, 1,   300,   1'b1};  // diff 45

    repeat (3) @(posedge clk);
    #1 rst = 0;

    chk("rst_ready8", 64'(rdy8), 1);
    chk("rst_valid8", 64'(rv8), 0);
    chk("rst_mis8", 64'(rm8), 0);
    chk("rst_cnt8", 64'(sc8), 0);
    chk("rst_err8", 64'(ec8), 0);
    chk("rst_sum8", 64'(es8), 0);
    chk("rst_max8", 64'(em8), 0);
    chk("rst_ready2", 64'(rdy2), 1);

    // Table of WIDTH=8 vectors
    for (int i = 0; i < 6; i++) begin
      send(0, tv[i].a, tv[i].b, tv[i].p, mis, lat);
      chk($sformatf("vec%0d_mis", i), 64'(mis), 64'(tv[i].mis));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 9);
    end
    chk("tbl_cnt", 64'(sc8), 6);
    chk("tbl_err", 64'(ec8), 3);
    chk("tbl_sum", 64'(es8), 70);
    chk("tbl_max", 64'(em8), 45);
`ifdef MRC_BIAS_EN
    chk("tbl_bias", 64'(bias8), 30);
`endif

    do_clear(0);
    chk("clr_cnt", 64'(sc8), 0);
    chk("clr_sum", 64'(es8), 0);
    chk("clr_max", 64'(em8), 0);

    // Back-to-back with in_valid held high: accepts every 10 cycles
    v8 = 1; a8 = 3; b8 = 5; p8 = 15;
    acc = 0; last = -1; pulses = 0; bad_gap = 0;
    for (int k = 0; k < 45; k++) begin
      if (rdy8) begin
        if (last >= 0 && k - last != 10) bad_gap = 1;
        last = k;
        acc++;
      end
      if (rv8) pulses++;
      tick();
    end
    v8 = 0;
    for (int k = 0; k < 12; k++) begin
      if (rv8) pulses++;
      tick();
    end
    chk("b2b_accepts", 64'(acc), 5);
    chk("b2b_gap", 64'(bad_gap), 0);
    chk("b2b_pulses", 64'(pulses), 64'(acc));
    chk("b2b_cnt", 64'(sc8), 64'(acc));
    chk("b2b_err", 64'(ec8), 0);

    // clear during MUL of a mismatching sample
    v8 = 1; a8 = 7; b8 = 9; p8 = 0;
    tick();
    v8 = 0;
    tick(); tick();
    do_clear(0);
    chk("midclr_ready", 64'(rdy8), 1);
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      if (rv8) pulses++;
      tick();
    end
    chk("midclr_no_result", 64'(pulses), 0);
    chk("midclr_cnt", 64'(sc8), 0);
    chk("midclr_err", 64'(ec8), 0);
    chk("midclr_sum", 64'(es8), 0);
    send(0, 7, 9, 63, mis, lat);
    chk("post_clr_mis", 64'(mis), 0);
    chk("post_clr_lat", 64'(lat), 9);
    chk("post_clr_cnt", 64'(sc8), 1);

    // clear and accept in the same cycle: accept is dropped
    v8 = 1; a8 = 2; b8 = 2; p8 = 1; clr8 = 1;
    tick();
    v8 = 0; clr8 = 0;
    chk("clr_acc_ready", 64'(rdy8), 1);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (rv8) pulses++;
      tick();
    end
    chk("clr_acc_no_result", 64'(pulses), 0);
    chk("clr_acc_cnt", 64'(sc8), 0);

    // WIDTH=2: exact products
    send(1, 2, 2, 4, mis, lat);
    chk("w2_a_mis", 64'(mis), 0);
    chk("w2_a_lat", 64'(lat), 3);
    send(1, 3, 3, 9, mis, lat);
    chk("w2_b_mis", 64'(mis), 0);
    send(1, 1, 3, 3, mis, lat);
    chk("w2_c_mis", 64'(mis), 0);
    chk("w2_cnt", 64'(sc2), 3);
    chk("w2_err", 64'(ec2), 0);
    chk("w2_sum", 64'(es2), 0);

    // WIDTH=2: mismatches
    do_clear(1);
    send(1, 3, 3, 8, mis, lat);
    chk("w2_d_mis", 64'(mis), 1);
    send(1, 2, 1, 5, mis, lat);
    chk("w2_e_mis", 64'(mis), 1);
    chk("w2m_err", 64'(ec2), 2);
    chk("w2m_sum", 64'(es2), 4);
    chk("w2m_max", 64'(em2), 3);

    // CNT_W=2 saturation: five samples with P = exact + 1
    do_clear(1);
    for (int i = 0; i < 5; i++) begin
      send(1, 1, 1, 2, mis, lat);
      chk($sformatf("sat%0d_mis", i), 64'(mis), 1);
    end
    chk("sat_cnt", 64'(sc2), 3);
    chk("sat_err", 64'(ec2), 3);
    chk("sat_sum", 64'(es2), 5);
    chk("sat_max", 64'(em2), 1);
`ifdef MRC_BIAS_EN
    chk("sat_bias", 64'(bias2), 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_result_checker.md
Name: mult_result_checker

Overview:
Synthesizable response-side checker for the multiplier design-space exploration flow. It accepts one (A, B, P) triple per transaction from the multiplier under test and recomputes the exact product with an iterative shift-add engine. It then accumulates error metrics (sample count, mismatch count, error sum, max error) that the RL reward extraction reads back, replacing per-sample $display scraping.

Parameters:
WIDTH, 8, operand width of A and B; P is 2*WIDTH.
CNT_W, 16, width of sample and mismatch counters.
ACC_W, 32, width of the absolute-error accumulator.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
clear  input  1  synchronous statistics clear; aborts any in-flight sample.
in_valid  input  1  triple valid.
in_ready  output  1  checker can accept a triple.
in_a  input  WIDTH  operand A, unsigned.
in_b  input  WIDTH  operand B, unsigned.
in_p  input  2*WIDTH  product from the multiplier under test.
res_valid  output  1  one-cycle pulse when a sample is scored.
res_mismatch  output  1  in_p != exact; valid with res_valid.
sample_cnt  output  CNT_W  samples scored, saturating.
err_cnt  output  CNT_W  mismatches, saturating.
err_sum  output  ACC_W  sum of |P - exact|, saturating.
err_max  output  2*WIDTH  largest |P - exact| seen.

Behaviour:
- Reset: FSM enters IDLE. in_ready=1. res_valid=0, res_mismatch=0. All counters, err_sum and err_max are 0. Internal latches are 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, p; clear the partial product; go to MUL.
  - MUL: exactly WIDTH cycles. Each cycle, if b[0], add a into the 2*WIDTH partial product; shift a left and b right. Iteration counter reaches WIDTH-1, then go to CMP.
  - CMP: compute diff = |p - exact| in 2*WIDTH bits (larger minus smaller). Update all metrics, pulse res_valid, go to IDLE.
- in_ready=0 in MUL and CMP; no input is dropped.
- Throughput: one sample per WIDTH+2 cycles.
- Latency: res_valid asserts WIDTH+1 cycles after the accept edge.
- Metric update in CMP:
  - sample_cnt += 1.
  - err_cnt += 1 if diff != 0.
  - err_sum += zero-extended diff.
  - err_max = max(err_max, diff).
- Saturation: sample_cnt and err_cnt hold at all-ones. err_sum clamps at 2^ACC_W-1 and never wraps.
- clear: priority over everything, including an accept in the same cycle.
  - Zeroes all metrics and res_valid.
  - Returns the FSM to IDLE and discards any in-flight sample.
  - in_ready is 1 in the cycle after clear.
- in_a, in_b, in_p are don't-care outside the accept cycle.
- Operand edges: a=0 or b=0 gives exact=0. Full-scale operands give exact=(2^WIDTH-1)^2, which fits 2*WIDTH bits with no overflow.
- rst mid-operation: immediate return to reset values; the partial sample is lost.

Optional Feature:
MRC_BIAS_EN:
- Defined: adds output err_bias, signed, ACC_W bits, reset 0, cleared by clear. It accumulates the signed value (p - exact) in CMP and saturates at the signed max and min. This gives the mean-error bias of approximate multipliers.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mrc_pkg holds:
  - FSM state enum {IDLE, MUL, CMP}.
  - Default width constants.
  - Saturating-add helper function.
- One natural sub-module: mrc_shift_add, the iterative exact-product engine.
  - Inputs: start, a, b.
  - Outputs: done, product.
  - It is reusable as a sequential reference multiplier.

Test Plan:
- WIDTH=2; send triples A=2 B=2 P=4, A=3 B=3 P=9, A=1 B=3 P=3 → three res_valid pulses with res_mismatch=0; sample_cnt=3, err_cnt=0, err_sum=0.
- WIDTH=2; A=3 B=3 P=8 then A=2 B=1 P=5 → mismatch on both; err_cnt=2, err_sum=4, err_max=3.
- WIDTH=8; A=255 B=255 P=65025 → no mismatch, confirming full-scale exact product. Also measure res_valid exactly 9 cycles after the accept edge, with in_ready low throughout.
- Hold in_valid high with back-to-back triples → one accept every 10 cycles (WIDTH=8), no sample lost or duplicated, sample_cnt matches the accepted count.
- Assert clear in the MUL state of a mismatching sample → no res_valid for that sample; metrics are 0; next triple is scored normally.
- CNT_W=2; feed 5 mismatching samples → sample_cnt and err_cnt hold at 3. With MRC_BIAS_EN defined, P=exact+1 five times gives err_bias=5.
